// File: rtl/data_mem_loader_if.sv
// data_mem_loader_if
//   Bundles the UART byte stream, the CPU store port and the memory write
//   port seen by data_mem_loader. Names are from the loader's point of view:
//   i_* are loader inputs, o_* are loader outputs.
//   Signals:
//     i_rx_data/i_rx_valid          byte + 1-cycle strobe from UART receiver
//     i_cpu_write_en/addr/wdata     CPU store request
//     o_mem_write_en/addr/wdata     memory write port (sampled on negedge)
//     o_cpu_stall, o_load_busy      CPU hold / loader active
//     o_load_done, o_load_err       1-cycle completion / error pulses
//   Modports: slave = loader, master = whoever drives the loader.
interface data_mem_loader_if #(parameter int ADDR_W = 4);
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              i_cpu_write_en;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [15:0]       i_cpu_wdata;
  logic              o_mem_write_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [15:0]       o_mem_wdata;
  logic              o_cpu_stall;
  logic              o_load_busy;
  logic              o_load_done;
  logic              o_load_err;

  modport slave (
    input  i_rx_data, i_rx_valid, i_cpu_write_en, i_cpu_addr, i_cpu_wdata,
    output o_mem_write_en, o_mem_addr, o_mem_wdata,
           o_cpu_stall, o_load_busy, o_load_done, o_load_err
  );

  modport master (
    output i_rx_data, i_rx_valid, i_cpu_write_en, i_cpu_addr, i_cpu_wdata,
    input  o_mem_write_en, o_mem_addr, o_mem_wdata,
           o_cpu_stall, o_load_busy, o_load_done, o_load_err
  );
endinterface

// File: rtl/data_mem_loader.sv
// data_mem_loader
//   Sequencer/arbiter in front of the data memory's single write port.
//   A frame is SYNC_BYTE followed by WORDS little-endian 16-bit words; each
//   word is written to BASE_ADDR+idx (wrapping) one cycle after its high
//   byte arrives. The CPU is stalled for the whole load; when idle, CPU
//   stores pass straight through to the memory.
//   Ports:
//     i_clk    rising-edge clock
//     i_reset  asynchronous, active-low reset
//     bus      data_mem_loader_if.slave (UART, CPU and memory signals)
//   Configuration macro: LOADER_CHECKSUM_EN
//     defined   -> a trailing XOR checksum byte follows the last word (CHK
//                  state); mismatch pulses o_load_err together with done.
//     undefined -> no checksum; o_load_err only reports an inter-byte timeout.
module data_mem_loader #(
  parameter int          ADDR_W    = 4,
  parameter int          WORDS     = 16,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  data_mem_loader_if.slave bus
);
  localparam int IDX_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_CHK} state_t;

  state_t            r_state;
  logic [7:0]        r_lo;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_wr_pend;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_done;
  logic              r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`else
  logic              r_fin;     // pending write is the last word of the frame
`endif

  logic w_busy, w_stall, w_tmo_hit, w_last;

  assign w_busy    = (r_state != S_IDLE);
  assign w_stall   = w_busy | r_wr_pend;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));

  // Loader owns the memory port while stalled; otherwise CPU pass-through.
  // The CPU write enable is gated by reset so nothing is stored while held.
  assign bus.o_mem_write_en = w_stall ? r_wr_pend : (bus.i_cpu_write_en & i_reset);
  assign bus.o_mem_addr     = w_stall ? r_addr    : bus.i_cpu_addr;
  assign bus.o_mem_wdata    = w_stall ? r_wdata   : bus.i_cpu_wdata;
  assign bus.o_cpu_stall    = w_stall;
  assign bus.o_load_busy    = w_busy;
  assign bus.o_load_done    = r_done;
  assign bus.o_load_err     = r_err;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_lo      <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr_pend <= 1'b0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= '0;
`else
      r_fin     <= 1'b0;
`endif
    end else begin
      r_wr_pend <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_done    <= 1'b0;
`else
      r_fin     <= 1'b0;
      r_done    <= r_fin;           // done one cycle after the final write
`endif
      // Address advances after each write pulse; it then shows the next
      // load address while the CPU is held.
      if (r_wr_pend) r_addr <= r_addr + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE) begin
            r_state <= S_LO;
            r_idx   <= '0;
            r_addr  <= ADDR_W'(BASE_ADDR);   // overrides a trailing increment
            r_tmo   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_LO: begin
          if (bus.i_rx_valid) begin
            r_lo    <= bus.i_rx_data;
            r_state <= S_HI;
            r_tmo   <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ bus.i_rx_data;
`endif
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo   <= r_tmo + 1'b1;
          end
        end
        S_HI: begin
          if (bus.i_rx_valid) begin
            r_wdata   <= {bus.i_rx_data, r_lo};
            r_wr_pend <= 1'b1;
            r_idx     <= r_idx + 1'b1;
            r_tmo     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ bus.i_rx_data;
            r_state   <= w_last ? S_CHK : S_LO;
`else
            r_fin     <= w_last;
            r_state   <= w_last ? S_IDLE : S_LO;
`endif
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo   <= r_tmo + 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (bus.i_rx_valid) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_err   <= (bus.i_rx_data != r_csum);
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo   <= r_tmo + 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_loader.sv
module tb_data_mem_loader;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_loader_if #(.ADDR_W(4)) ifa ();
  data_mem_loader_if #(.ADDR_W(4)) ifb ();

  data_mem_loader #(.ADDR_W(4), .WORDS(2), .BASE_ADDR(0), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO))
    dut_a (.i_clk(clk), .i_reset(rst_n), .bus(ifa));
  data_mem_loader #(.ADDR_W(4), .WORDS(4), .BASE_ADDR(14), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO))
    dut_b (.i_clk(clk), .i_reset(rst_n), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Loader-side writes (stall high) and pulse counters, sampled mid-cycle.
  logic [19:0] qa[$];
  logic [19:0] qb[$];
  int done_a = 0, err_a = 0, done_b = 0, err_b = 0;
  always @(negedge clk) begin
    #2;
    if (ifa.o_mem_write_en && ifa.o_cpu_stall) qa.push_back({ifa.o_mem_addr, ifa.o_mem_wdata});
    if (ifb.o_mem_write_en && ifb.o_cpu_stall) qb.push_back({ifb.o_mem_addr, ifb.o_mem_wdata});
    if (ifa.o_load_done) done_a++;
    if (ifa.o_load_err)  err_a++;
    if (ifb.o_load_done) done_b++;
    if (ifb.o_load_err)  err_b++;
  end

  typedef struct {
    logic        rv;  logic [7:0] rd;
    logic        cwe; logic [3:0] ca; logic [15:0] cd;
    logic        ewe; logic [3:0] ea; logic [15:0] ed;
    logic        est; logic       ebz; logic edn; logic eer;
  } vec_t;

  vec_t tv[8];

  task automatic send_a(input logic [7:0] b);
    @(negedge clk); ifa.i_rx_valid = 1'b1; ifa.i_rx_data = b;
  endtask
  task automatic send_b(input logic [7:0] b);
    @(negedge clk); ifb.i_rx_valid = 1'b1; ifb.i_rx_data = b;
  endtask

  initial begin
    int sa, sb, da, ea, db, eb, first_err, nerr, nwe, ndone;
    logic [7:0] fb[$];
    logic [19:0] expb[4];

    ifa.i_rx_valid = 0; ifa.i_rx_data = 0;
    ifa.i_cpu_write_en = 1; ifa.i_cpu_addr = 4'd3; ifa.i_cpu_wdata = 16'h1234;
    ifb.i_rx_valid = 0; ifb.i_rx_data = 0;
    ifb.i_cpu_write_en = 0; ifb.i_cpu_addr = 0; ifb.i_cpu_wdata = 0;

    // ---- reset held with a CPU store pending
    #13;
    chk("rst stall", ifa.o_cpu_stall, 0);
    chk("rst busy",  ifa.o_load_busy, 0);
    chk("rst done",  ifa.o_load_done, 0);
    chk("rst err",   ifa.o_load_err, 0);
    chk("rst we",    ifa.o_mem_write_en, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post-rst we",   ifa.o_mem_write_en, 1);
    chk("post-rst addr", ifa.o_mem_addr, 3);
    chk("post-rst data", ifa.o_mem_wdata, 16'h1234);

    // ---- table: frame 34 12 78 56 with CPU store held throughout
    tv[0] = '{1'b1, 8'hA5, 1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd9, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 8'h34, 1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b1, 8'h12, 1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[3] = '{1'b1, 8'h78, 1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b1, 8'h56, 1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef LOADER_CHECKSUM_EN
    tv[5] = '{1'b1, 8'h08, 1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd1, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    tv[5] = '{1'b0, 8'h00, 1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd1, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    tv[6] = '{1'b0, 8'h00, 1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd9, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b0, 8'h00, 1'b1, 4'd3, 16'h1234, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifa.i_rx_valid = tv[i].rv; ifa.i_rx_data = tv[i].rd;
      ifa.i_cpu_write_en = tv[i].cwe; ifa.i_cpu_addr = tv[i].ca; ifa.i_cpu_wdata = tv[i].cd;
      #1;
      chk($sformatf("row%0d we", i),    ifa.o_mem_write_en, tv[i].ewe);
      chk($sformatf("row%0d addr", i),  ifa.o_mem_addr, tv[i].ea);
      if (tv[i].ewe) chk($sformatf("row%0d data", i), ifa.o_mem_wdata, tv[i].ed);
      chk($sformatf("row%0d stall", i), ifa.o_cpu_stall, tv[i].est);
      chk($sformatf("row%0d busy", i),  ifa.o_load_busy, tv[i].ebz);
      chk($sformatf("row%0d done", i),  ifa.o_load_done, tv[i].edn);
      chk($sformatf("row%0d err", i),   ifa.o_load_err, tv[i].eer);
    end
    @(negedge clk); ifa.i_cpu_write_en = 0; ifa.i_rx_valid = 0;

    // ---- timeout: A5, 11, then silence
    sa = qa.size(); da = done_a;
    send_a(8'hA5); send_a(8'h11);
    first_err = 0; nerr = 0; nwe = 0;
    for (int n = 1; n <= TMO + 4; n++) begin
      @(negedge clk); ifa.i_rx_valid = 0; #1;
      if (n == TMO - 1) chk("tmo busy early", ifa.o_load_busy, 1);
      if (ifa.o_load_err) begin nerr++; if (first_err == 0) first_err = n; end
      if (ifa.o_mem_write_en) nwe++;
    end
    chk("tmo err count", nerr, 1);
    chk("tmo err window", (first_err >= TMO && first_err <= TMO + 1), 1);
    chk("tmo no write", nwe, 0);
    chk("tmo no done", done_a - da, 0);
    chk("tmo idle", ifa.o_load_busy, 0);

    // ---- reset mid-frame aborts without pulses
    da = done_a; ea = err_a;
    send_a(8'hA5); send_a(8'h34);
    @(negedge clk); ifa.i_rx_valid = 0; #2; rst_n = 1'b0; #1;
    chk("midrst busy",  ifa.o_load_busy, 0);
    chk("midrst stall", ifa.o_cpu_stall, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst no done", done_a - da, 0);
    chk("midrst no err",  err_a - ea, 0);

    // ---- address wrap on B: base 14, 4 words, SYNC value used as data
    sb = qb.size(); db = done_b; eb = err_b;
    fb = '{8'hA5, 8'hA5, 8'hA5, 8'hEF, 8'hBE, 8'hA5, 8'h00, 8'h21, 8'h43};
`ifdef LOADER_CHECKSUM_EN
    fb.push_back(8'h96);
`endif
    foreach (fb[k]) send_b(fb[k]);
    @(negedge clk); ifb.i_rx_valid = 0;
    repeat (4) @(negedge clk);
    expb = '{{4'd14, 16'hA5A5}, {4'd15, 16'hBEEF}, {4'd0, 16'h00A5}, {4'd1, 16'h4321}};
    chk("wrap count", qb.size() - sb, 4);
    for (int k = 0; k < 4; k++)
      if (sb + k < qb.size()) chk($sformatf("wrap w%0d", k), qb[sb + k], expb[k]);
    chk("wrap done", done_b - db, 1);
    chk("wrap err",  err_b - eb, 0);
    chk("wrap idle", ifb.o_cpu_stall, 0);

`ifdef LOADER_CHECKSUM_EN
    // ---- bad checksum: done and err together, words still committed
    sa = qa.size();
    send_a(8'hA5); send_a(8'h34); send_a(8'h12); send_a(8'h78); send_a(8'h56); send_a(8'h09);
    @(negedge clk); ifa.i_rx_valid = 0; #1;
    chk("bad cs done", ifa.o_load_done, 1);
    chk("bad cs err",  ifa.o_load_err, 1);
    repeat (2) @(negedge clk);
    chk("bad cs writes", qa.size() - sa, 2);
    if (qa.size() >= sa + 2) begin
      chk("bad cs w0", qa[sa], {4'd0, 16'h1234});
      chk("bad cs w1", qa[sa + 1], {4'd1, 16'h5678});
    end
`endif

    // ---- idle pass-through after all of the above
    @(negedge clk); ifa.i_cpu_write_en = 1; ifa.i_cpu_addr = 4'd7; ifa.i_cpu_wdata = 16'hC0DE; #1;
    chk("final pass we",   ifa.o_mem_write_en, 1);
    chk("final pass addr", ifa.o_mem_addr, 7);
    chk("final pass data", ifa.o_mem_wdata, 16'hC0DE);
    @(negedge clk); ifa.i_cpu_write_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
